// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared data memory constants and alignment helper
package mem_pkg;

    localparam logic [2:0] XFER_B = 3'd1;
    localparam logic [2:0] XFER_H = 3'd2;
    localparam logic [2:0] XFER_W = 3'd4;

    localparam logic PORT_LSU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Legal size and natural alignment; any other size is reported as not aligned.
    function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (size)
            XFER_B:  ok = 1'b1;
            XFER_H:  ok = (addr_lo[0] == 1'b0);
            XFER_W:  ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - request/response and data_mem bus bundle
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_write;
    logic [1:0][2:0]        req_size;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0]             rsp_valid;
    logic                   rsp_err;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   mem_write;
    logic                   mem_read;
    logic [2:0]             xfer_size;
    logic [ADDR_W-1:0]      address;
    logic [DATA_W-1:0]      w_data;
    logic [DATA_W-1:0]      r_data;

    // Requesters plus the memory itself, seen from outside the arbiter.
    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, r_data,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_write, mem_read, xfer_size, address, w_data
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, r_data,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_write, mem_read, xfer_size, address, w_data
    );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin or fixed-priority grant
module rr_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_grant;

    // Single requester wins outright; contention goes to the port not served last.
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            if (req == 2'b11) begin
                if ((FIXED_PRIO != 0) || last_grant) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end else begin
                gnt = req;
            end
        end
    end

    // Remember the last served port; starts at 1 so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (|gnt) begin
            last_grant <= gnt[1];
        end
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares data_mem between the LSU and the DMA loader
module data_mem_arbiter import mem_pkg::*; #(
    parameter int FIXED_PRIO = 0,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input logic                clk,
    input logic                reset,
    data_mem_arbiter_if.slave  bus
);
    logic [1:0]        gnt;
    logic              gnt_any;
    logic              gnt_port;
    logic              sel_write;
    logic [2:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_legal;

    logic              rsp_pend;
    logic              rsp_port;
    logic              rsp_err_q;
    logic              rsp_load_q;

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (bus.req_valid),
        .gnt   (gnt)
    );

    assign bus.req_ready = gnt;
    assign gnt_any       = |gnt;
    assign gnt_port      = gnt[PORT_DMA];

    // Mux the winning port's request fields and check size/alignment.
    always_comb begin
        sel_write = bus.req_write[gnt_port];
        sel_size  = bus.req_size[gnt_port];
        sel_addr  = bus.req_addr[gnt_port];
        sel_wdata = bus.req_wdata[gnt_port];
        sel_legal = is_aligned(sel_size, sel_addr[1:0]);
    end

    // Drive data_mem only for a legal grant; illegal requests are swallowed here.
    always_comb begin
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        bus.xfer_size = '0;
        bus.address   = '0;
        bus.w_data    = '0;
        if (gnt_any && sel_legal) begin
            bus.mem_write = sel_write;
            bus.mem_read  = ~sel_write;
            bus.xfer_size = sel_size;
            bus.address   = sel_addr;
            bus.w_data    = sel_wdata;
        end
    end

    // Capture each accepted transfer so its response lands exactly one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_pend   <= 1'b0;
            rsp_port   <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
        end else begin
            rsp_pend   <= gnt_any;
            rsp_port   <= gnt_port;
            rsp_err_q  <= gnt_any && !sel_legal;
            rsp_load_q <= gnt_any && sel_legal && !sel_write;
        end
    end

    // Route the response to its requester; reset blanks a response already in flight.
    always_comb begin
        bus.rsp_valid = 2'b00;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = '0;
        if (rsp_pend && !reset) begin
            bus.rsp_valid[PORT_LSU] = (rsp_port == PORT_LSU);
            bus.rsp_valid[PORT_DMA] = (rsp_port == PORT_DMA);
            bus.rsp_err             = rsp_err_q;
            if (rsp_load_q) begin
                bus.rsp_rdata = bus.r_data;
            end
        end
    end
endmodule
